// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit divider sequencer for the EX stage.
// Accepts a signed or unsigned divide request, runs a 32-step restoring
// division (one quotient bit per cycle, MSB first) and presents the
// remainder on wHiData and the quotient on wLoData with a one-cycle done
// pulse. A zero divisor skips the calculation and reports ZERO_Q.
module div_sequencer #(
  parameter logic [31:0] ZERO_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        whi,
  output logic        wlo,
  output logic [31:0] wHiData,
  output logic [31:0] wLoData,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of a 32-bit operand; only negated when the operation is signed.
  // 32'h8000_0000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      abs32 = 32'd0 - v;
    end else begin
      abs32 = v;
    end
  endfunction

  // Two's complement negation applied only when requested.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    if (neg) begin
      cond_neg32 = 32'd0 - v;
    end else begin
      cond_neg32 = v;
    end
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic [31:0] whi_data_r;
  logic [31:0] wlo_data_r;
  logic        div_zero_r;

  logic        accept_s;
  logic        opb_zero_s;
  logic        last_step_s;
  logic        step_s;
  logic [32:0] rem_shift_s;
  logic [32:0] diff_s;
  logic        q_bit_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic        busy_s;
  logic        done_s;

  // Request qualification and one restoring-division step.
  always_comb begin
    accept_s    = (state_r == IDLE) && start && !cancel;
    opb_zero_s  = (opb == 32'd0);
    step_s      = (state_r == CALC) && !cancel;
    last_step_s = (cnt_r == 5'd31);
    // Bring down the next dividend bit (held in the quotient register MSB).
    rem_shift_s = {rem_r, quo_r[31]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    q_bit_s     = ~diff_s[32];
    if (q_bit_s) begin
      rem_next_s = diff_s[31:0];
    end else begin
      rem_next_s = rem_shift_s[31:0];
    end
    quo_next_s  = {quo_r[30:0], q_bit_s};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: cancel always returns to IDLE; start only matters in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (opb_zero_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = CALC;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cancel) begin
          state_next_s = IDLE;
        end else if (last_step_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode: busy follows the state register, done is masked by cancel.
  always_comb begin
    busy_s = (state_r != IDLE);
    if (state_r == DONE) begin
      done_s = !cancel;
    end else begin
      done_s = 1'b0;
    end
  end

  assign busy     = busy_s;
  assign done     = done_s;
  assign whi      = done_s;
  assign wlo      = done_s;
  assign wHiData  = whi_data_r;
  assign wLoData  = wlo_data_r;
  assign div_zero = div_zero_r;

  // Datapath: operand capture, iteration, and result registers that hold
  // the last completed result until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 5'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      dvs_r      <= 32'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      whi_data_r <= 32'd0;
      wlo_data_r <= 32'd0;
      div_zero_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= 5'd0;
      rem_r   <= 32'd0;
      quo_r   <= abs32(opa, signed_op);
      dvs_r   <= abs32(opb, signed_op);
      neg_q_r <= signed_op && (opa[31] ^ opb[31]);
      neg_r_r <= signed_op && opa[31];
      if (opb_zero_s) begin
        whi_data_r <= opa;
        wlo_data_r <= ZERO_Q;
        div_zero_r <= 1'b1;
      end
    end else if (step_s) begin
      cnt_r <= cnt_r + 5'd1;
      rem_r <= rem_next_s;
      quo_r <= quo_next_s;
      if (last_step_s) begin
        whi_data_r <= cond_neg32(rem_next_s, neg_r_r);
        wlo_data_r <= cond_neg32(quo_next_s, neg_q_r);
        div_zero_r <= 1'b0;
      end
    end else if (state_r != CALC) begin
      cnt_r <= 5'd0;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        whi;
  logic        wlo;
  logic [31:0] wHiData;
  logic [31:0] wLoData;
  logic        div_zero;

  int total;
  int bad;

  div_sequencer #(.ZERO_Q(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .opa(opa), .opb(opb), .cancel(cancel), .busy(busy), .done(done),
    .whi(whi), .wlo(wlo), .wHiData(wHiData), .wLoData(wLoData),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Pulse start for one cycle; returns at the sampling point of cycle T+1.
  task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; signed_op = s; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_op = 1'b0;
    opa = 32'd0; opb = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b expected 0", busy); end
    total++; if ({done, whi, wlo} !== 3'b000) begin bad++; $display("FAIL reset_done got %b expected 000", {done, whi, wlo}); end
    total++; if (wHiData !== 32'd0) begin bad++; $display("FAIL reset_hi got %h expected 0", wHiData); end
    total++; if (wLoData !== 32'd0) begin bad++; $display("FAIL reset_lo got %h expected 0", wLoData); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got %b expected 0", div_zero); end
  endtask

  task automatic test_unsigned();
    drive_start(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (busy !== (k <= 33)) begin bad++; $display("FAIL unsigned_busy k=%0d got %b expected %b", k, busy, (k <= 33)); end
      total++;
      if ({done, whi, wlo} !== {3{k == 33}}) begin bad++; $display("FAIL unsigned_done k=%0d got %b expected %b", k, {done, whi, wlo}, {3{k == 33}}); end
      if (k == 33) begin
        total++; if (wLoData !== 32'd14) begin bad++; $display("FAIL unsigned_q got %h expected %h", wLoData, 32'd14); end
        total++; if (wHiData !== 32'd2) begin bad++; $display("FAIL unsigned_r got %h expected %h", wHiData, 32'd2); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL unsigned_dz got %b expected 0", div_zero); end
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] a_tab [3];
    logic [31:0] b_tab [3];
    logic [31:0] q_tab [3];
    logic [31:0] r_tab [3];
    a_tab[0] = 32'hFFFF_FFF9; b_tab[0] = 32'd2;          q_tab[0] = 32'hFFFF_FFFD; r_tab[0] = 32'hFFFF_FFFF;
    a_tab[1] = 32'd7;         b_tab[1] = 32'hFFFF_FFFE; q_tab[1] = 32'hFFFF_FFFD; r_tab[1] = 32'd1;
    a_tab[2] = 32'h8000_0000; b_tab[2] = 32'hFFFF_FFFF; q_tab[2] = 32'h8000_0000; r_tab[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      drive_start(1'b1, a_tab[i], b_tab[i]);
      repeat (32) @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL signed_done[%0d] got %b expected 1", i, done); end
      total++; if (wLoData !== q_tab[i]) begin bad++; $display("FAIL signed_q[%0d] got %h expected %h", i, wLoData, q_tab[i]); end
      total++; if (wHiData !== r_tab[i]) begin bad++; $display("FAIL signed_r[%0d] got %h expected %h", i, wHiData, r_tab[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    drive_start(1'b0, 32'd5, 32'd0);
    total++; if ({busy, done, whi, wlo} !== 4'b1111) begin bad++; $display("FAIL dz_done got %b expected 1111", {busy, done, whi, wlo}); end
    total++; if (wLoData !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_q got %h expected ffffffff", wLoData); end
    total++; if (wHiData !== 32'd5) begin bad++; $display("FAIL dz_r got %h expected 5", wHiData); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got %b expected 1", div_zero); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL dz_idle got %b expected 00", {busy, done}); end
    drive_start(1'b0, 32'd9, 32'd3);
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) begin
        total++; if (div_zero !== 1'b1 || wLoData !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_hold got %b/%h expected 1/ffffffff", div_zero, wLoData); end
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL dz_next_done got %b expected 1", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got %b expected 0", div_zero); end
    total++; if ({wHiData, wLoData} !== {32'd0, 32'd3}) begin bad++; $display("FAIL dz_next_res got %h/%h expected 0/3", wHiData, wLoData); end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    int seen;
    seen = 0;
    drive_start(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) begin cancel = 1'b1; #1; end
      if (done !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL cancel_no_done got %0d pulses expected 0", seen); end
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got %b expected 0", busy); end
    total++; if (wLoData !== 32'd3) begin bad++; $display("FAIL cancel_hold got %h expected 3", wLoData); end
    // New request in the first IDLE cycle after the cancel.
    start = 1'b1; signed_op = 1'b0; opa = 32'd1000; opb = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL cancel_restart_done got %b expected 1", done); end
    total++; if ({wHiData, wLoData} !== {32'd0, 32'd100}) begin bad++; $display("FAIL cancel_restart_res got %h/%h expected 0/64", wHiData, wLoData); end
    @(negedge clk);
    // Cancel in DONE suppresses the pulse.
    drive_start(1'b0, 32'd8, 32'd2);
    repeat (32) @(negedge clk);
    cancel = 1'b1; #1;
    total++; if ({done, whi, wlo} !== 3'b000) begin bad++; $display("FAIL cancel_in_done got %b expected 000", {done, whi, wlo}); end
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_in_done_busy got %b expected 0", busy); end
    // Start together with cancel in IDLE is not accepted.
    start = 1'b1; cancel = 1'b1; opa = 32'd6; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_start_idle got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int extra;
    extra = 0;
    drive_start(1'b0, 32'd50, 32'd5);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) begin start = 1'b1; opa = 32'd99; opb = 32'd9; end
      if (k == 6) start = 1'b0;
      if (done !== (k == 33)) extra++;
      if (k == 33) begin
        total++; if ({wHiData, wLoData} !== {32'd0, 32'd10}) begin bad++; $display("FAIL b2b_first_res got %h/%h expected 0/a", wHiData, wLoData); end
      end
    end
    total++; if (extra != 0) begin bad++; $display("FAIL b2b_done_timing got %0d bad cycles expected 0", extra); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got %b expected 0", busy); end
    // Immediate new request in the first IDLE cycle after DONE.
    start = 1'b1; signed_op = 1'b0; opa = 32'd20; opb = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got %b expected 1", done); end
    total++; if ({wHiData, wLoData} !== {32'd2, 32'd3}) begin bad++; $display("FAIL b2b_second_res got %h/%h expected 2/3", wHiData, wLoData); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    drive_start(1'b1, 32'hFFFF_FF9C, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    total++; if ({busy, done, whi, wlo, div_zero} !== 5'b00000) begin bad++; $display("FAIL rst_mid_ctl got %b expected 00000", {busy, done, whi, wlo, div_zero}); end
    total++; if ({wHiData, wLoData} !== 64'd0) begin bad++; $display("FAIL rst_mid_data got %h/%h expected 0/0", wHiData, wLoData); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_quiet got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter ZERO_Q, default 32'hFFFF_FFFF: quotient (LO) reported for a divide by zero.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1: division request from EX, qualified with the operand inputs in the same cycle.
REQ-005 SHALL have port signed_op, input, 1: 1 = Div (signed), 0 = Divu (unsigned).
REQ-006 SHALL have port opa, input, 32: dividend (regaData).
REQ-007 SHALL have port opb, input, 32: divisor (regbData).
REQ-008 SHALL have port cancel, input, 1: exception flush; aborts any operation in flight.
REQ-009 SHALL have port busy, output, 1: pipeline stall request while an operation is in flight.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports whi and wlo, output, 1 each: HI/LO write enables; both equal done.
REQ-012 SHALL have port wHiData, output, 32: remainder.
REQ-013 SHALL have port wLoData, output, 32: quotient.
REQ-014 SHALL have port div_zero, output, 1: set with done when opb was 0.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 SHALL accept start only in IDLE with cancel low, capturing opa, opb and signed_op in cycle T.
REQ-017 SHALL ignore start in CALC and DONE (no effect on the result or the timing).
REQ-018 SHALL, when accepted with opb != 0, be in CALC for cycles T+1..T+32 (5-bit counter, one restoring quotient bit per cycle, MSB first), then in DONE at T+33, then in IDLE at T+34.
REQ-019 SHALL, when accepted with opb == 0, go IDLE -> DONE at T+1 with wLoData = ZERO_Q, wHiData = captured opa, div_zero = 1.
REQ-020 SHALL, for signed operations, divide the absolute values, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-021 SHALL, for signed 32'h8000_0000 / 32'hFFFF_FFFF, produce quotient 32'h8000_0000 and remainder 0.
REQ-022 SHALL drive busy = 1 exactly while the state is CALC or DONE (registered; low in IDLE).
REQ-023 SHALL drive done = whi = wlo = (state == DONE) && !cancel.
REQ-024 SHALL hold wHiData, wLoData and div_zero at their last completed values until the next completion overwrites them.
REQ-025 SHALL clear div_zero at the next non-zero-divisor completion.
REQ-026 SHALL, on cancel in CALC or DONE, enter IDLE at the next edge, discard the partial result, and suppress done, whi and wlo in the cancel cycle.
REQ-027 SHALL treat cancel and start together in IDLE as cancel only; the request is not accepted.
REQ-028 SHALL accept a new start in the first IDLE cycle after DONE or after a cancel.

Reset
REQ-029 SHALL, on rst high at a clock edge, enter IDLE, abandon any operation mid-flight, and never emit done for it.
REQ-030 SHALL drive, after reset: busy = 0, done = 0, whi = 0, wlo = 0, wHiData = 0, wLoData = 0, div_zero = 0, counter = 0.
REQ-031 SHALL give rst priority over start and cancel in the same cycle.

Verification
REQ-032 Unsigned 100 / 7, start at T -> busy T+1..T+33; done pulse at T+33; wLoData = 14; wHiData = 2; div_zero = 0.
REQ-033 Signed -7 / 2 -> at T+33: wLoData = 32'hFFFF_FFFD, wHiData = 32'hFFFF_FFFF. Signed 7 / -2 -> at T+33: wLoData = 32'hFFFF_FFFD, wHiData = 1.
REQ-034 Unsigned 5 / 0 -> done at T+1; wLoData = 32'hFFFF_FFFF; wHiData = 5; div_zero = 1; the next 9 / 3 clears div_zero.
REQ-035 Start at T, cancel at T+10 -> no done; busy low at T+11; new start at T+11 completes at T+44 with correct results.
REQ-036 Second start at T+5 with other operands -> ignored; first result delivered at T+33; no second done.
REQ-037 rst at T+20 mid-operation -> all outputs 0 at T+21; no done thereafter. Also run signed 32'h8000_0000 / -1 -> wLoData = 32'h8000_0000, wHiData = 0.
